// File: rtl/mac_hasher_pkg.sv
// Shared definitions for the MAC header address hasher and the MAC lookup memory model:
// FSM state encoding, CRC-32 constants and the fold-XOR / CRC-32 helper functions.
package mac_hasher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DA   = 2'd1,
    SA   = 2'd2,
    TAIL = 2'd3
  } hasher_state_t;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  localparam int unsigned MAC_MAX_W = 128;
  localparam int unsigned IDX_W     = $clog2(MAC_MAX_W);

  // Bit i of the MAC lands in address bit i % size_out, which is the XOR of LSB-aligned chunks.
  function automatic logic [MAC_MAX_W-1:0] fold_xor(input logic [MAC_MAX_W-1:0] mac,
                                                    input int unsigned size_in,
                                                    input int unsigned size_out);
    logic [MAC_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAC_MAX_W; i++)
      if (i < size_in) r[IDX_W'(i % size_out)] ^= mac[IDX_W'(i)];
    return r;
  endfunction

  function automatic logic [31:0] crc32_step(input logic [31:0]          crc,
                                             input logic [MAC_MAX_W-1:0] data,
                                             input int unsigned          width);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < MAC_MAX_W; i++)
      if (i < width) begin
        fb = c[31] ^ data[IDX_W'(width - 1 - i)];
        c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
      end
    return c;
  endfunction

endpackage

// File: rtl/mac_addr_hash.sv
// Per-MAC hash engine: absorbs one MAC a beat at a time (MS beat first) and presents its address.
// Fold-XOR by default; low bits of a per-beat CRC-32 when MAC_HASH_CRC_EN is defined.
module mac_addr_hash
  import mac_hasher_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = 8,
  parameter int unsigned pSIZE_IN    = 48,
  parameter int unsigned pSIZE_OUT   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   first,
  input  logic [pDATA_WIDTH-1:0] data,
  output logic [pSIZE_OUT-1:0]   hash
);

`ifdef MAC_HASH_CRC_EN
  if (pSIZE_OUT > 32 || pSIZE_OUT > pSIZE_IN) begin : g_chk_crc_w
    $error("mac_addr_hash: CRC hash needs pSIZE_OUT <= 32 and <= pSIZE_IN");
  end

  logic [31:0] crc;

  always_ff @(posedge clk) begin
    if (rst)
      crc <= CRC32_INIT;
    else if (en)
      crc <= crc32_step(first ? CRC32_INIT : crc, MAC_MAX_W'(data), pDATA_WIDTH);
  end

  assign hash = crc[pSIZE_OUT-1:0];
`else
  logic [pSIZE_IN-1:0] mac;

  // The first beat clears older bits so the truncating shift also covers pDATA_WIDTH == pSIZE_IN.
  always_ff @(posedge clk) begin
    if (rst)
      mac <= '0;
    else if (en)
      mac <= pSIZE_IN'({first ? {pSIZE_IN{1'b0}} : mac, data});
  end

  assign hash = pSIZE_OUT'(fold_xor(MAC_MAX_W'(mac), pSIZE_IN, pSIZE_OUT));
`endif

endmodule

// File: rtl/mac_hdr_addr_hasher.sv
// Captures DA and SA of each framed header, hashes both and offers them as a pair on valid/ready.
// Hash selection: fold-XOR by default, CRC-32 when MAC_HASH_CRC_EN is defined.
module mac_hdr_addr_hasher
  import mac_hasher_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = 8,
  parameter int unsigned pSIZE_IN    = 48,
  parameter int unsigned pSIZE_OUT   = 14
) (
  input  logic                   iclk,
  input  logic                   irst,
  input  logic [pDATA_WIDTH-1:0] idata,
  input  logic                   ivalid,
  input  logic                   isop,
  input  logic                   ieop,
  output logic [pSIZE_OUT-1:0]   oaddr_da,
  output logic [pSIZE_OUT-1:0]   oaddr_sa,
  output logic                   ovalid,
  input  logic                   iready,
  output logic                   oerr,
  output logic                   oovf
);

  localparam int unsigned     BEATS = pSIZE_IN / pDATA_WIDTH;
  localparam int unsigned     CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if (pSIZE_IN % pDATA_WIDTH != 0) begin : g_chk_beats
    $error("mac_hdr_addr_hasher: pSIZE_IN must be a multiple of pDATA_WIDTH");
  end
  if (pSIZE_OUT < 1 || pSIZE_OUT > pSIZE_IN) begin : g_chk_out
    $error("mac_hdr_addr_hasher: pSIZE_OUT must be in 1..pSIZE_IN");
  end

  hasher_state_t         state;
  logic [CNT_W-1:0]      cnt;
  logic                  pair_done;
  logic                  da_en;
  logic                  sa_en;
  logic                  sa_first;
  logic [pSIZE_OUT-1:0]  hash_da;
  logic [pSIZE_OUT-1:0]  hash_sa;

  assign da_en    = ivalid & (isop | (state == DA));
  assign sa_en    = ivalid & ~isop & (state == SA);
  assign sa_first = (cnt == '0);

  mac_addr_hash #(
    .pDATA_WIDTH(pDATA_WIDTH),
    .pSIZE_IN   (pSIZE_IN),
    .pSIZE_OUT  (pSIZE_OUT)
  ) u_hash_da (
    .clk  (iclk),
    .rst  (irst),
    .en   (da_en),
    .first(isop),
    .data (idata),
    .hash (hash_da)
  );

  mac_addr_hash #(
    .pDATA_WIDTH(pDATA_WIDTH),
    .pSIZE_IN   (pSIZE_IN),
    .pSIZE_OUT  (pSIZE_OUT)
  ) u_hash_sa (
    .clk  (iclk),
    .rst  (irst),
    .en   (sa_en),
    .first(sa_first),
    .data (idata),
    .hash (hash_sa)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state     <= IDLE;
      cnt       <= '0;
      pair_done <= 1'b0;
      oerr      <= 1'b0;
    end else begin
      pair_done <= 1'b0;
      oerr      <= 1'b0;
      if (ivalid) begin
        if (isop) begin
          // The sop beat is DA beat 0, wherever the FSM was.
          if (ieop) begin
            oerr  <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
          end else if (LAST == '0) begin
            state <= SA;
            cnt   <= '0;
          end else begin
            state <= DA;
            cnt   <= CNT_W'(1);
          end
        end else begin
          case (state)
            DA: begin
              if (ieop) begin
                oerr  <= 1'b1;
                state <= IDLE;
                cnt   <= '0;
              end else if (cnt == LAST) begin
                state <= SA;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            SA: begin
              if (cnt == LAST) begin
                pair_done <= 1'b1;
                state     <= ieop ? IDLE : TAIL;
                cnt       <= '0;
              end else if (ieop) begin
                oerr  <= 1'b1;
                state <= IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            TAIL: begin
              if (ieop) state <= IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // pair_done lags the last SA beat by one edge, so the engines' hashes are settled when loaded.
  always_ff @(posedge iclk) begin
    if (irst) begin
      ovalid   <= 1'b0;
      oaddr_da <= '0;
      oaddr_sa <= '0;
      oovf     <= 1'b0;
    end else begin
      oovf <= 1'b0;
      if (pair_done) begin
        if (ovalid & ~iready) begin
          oovf <= 1'b1;
        end else begin
          ovalid   <= 1'b1;
          oaddr_da <= hash_da;
          oaddr_sa <= hash_sa;
        end
      end else if (ovalid & iready) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule
